// File: rtl/ds1124_pkg.sv
// Shared widths and state encoding for the DS1124 responder.
package ds1124_pkg;

  localparam int unsigned DS1124_DELAY_W        = 8;
  localparam int unsigned DS1124_BITS_PER_FRAME = 8;
  localparam int unsigned DS1124_CNT_W          = 4;

  typedef enum logic {
    IDLE,
    SHIFT
  } responder_state_t;

endpackage

// File: rtl/ds1124_input_sync.sv
// One serial line: synchronizer chain, optional glitch filter
// (DS1124_RESP_GLITCH_FILTER_EN), history flop and edge pulses.
module ds1124_input_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("ds1124_input_sync: SYNC_STAGES must be >= 2");
  end
  if ((FILTER_LEN < 1) || (FILTER_LEN > 7)) begin : g_bad_filter
    $error("ds1124_input_sync: FILTER_LEN must be 1..7");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   level;
  logic                   hist_q;

  // Metastability chain; left unreset so a line held high through reset
  // does not look like a fresh edge afterwards.
  always_ff @(posedge clk_i) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef DS1124_RESP_GLITCH_FILTER_EN
  localparam int unsigned FCNT_W = 3;

  logic [FCNT_W-1:0] fcnt_q;
  logic              filt_q;

  // Accept a new level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q <= sync_lvl;
      fcnt_q <= '0;
    end else if (sync_lvl != filt_q) begin
      if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
        filt_q <= sync_lvl;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FCNT_W'(1);
      end
    end else begin
      fcnt_q <= '0;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_lvl;
`endif

  // History flop for edge detection.
  always_ff @(posedge clk_i) begin
    hist_q <= level;
  end

  assign level_o = level;
  assign rise_o  = ~rst_i & level & ~hist_q;
  assign fall_o  = ~rst_i & ~level & hist_q;

endmodule

// File: rtl/ds1124_responder.sv
// Device-side DS1124 3-wire serial delay-line model, oversampled on clk.
// Optional input glitch filter: DS1124_RESP_GLITCH_FILTER_EN.
module ds1124_responder
  import ds1124_pkg::*;
#(
  parameter logic [DS1124_DELAY_W-1:0] INIT_DELAY  = '0,
  parameter int unsigned               SYNC_STAGES = 2,
  parameter int unsigned               FILTER_LEN  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ds1124_clk,
  input  logic                      ds1124_d,
  input  logic                      ds1124_e,
  output logic                      ds1124_q,
  output logic [DS1124_DELAY_W-1:0] delay_setting,
  output logic                      update_strobe,
  output logic                      frame_error,
  output logic                      busy
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic d_level, d_rise, d_fall;
  logic e_level, e_rise, e_fall;

  ds1124_input_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sync_clk (
    .clk_i(clk), .rst_i(rst), .line_i(ds1124_clk),
    .level_o(sclk_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  ds1124_input_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sync_d (
    .clk_i(clk), .rst_i(rst), .line_i(ds1124_d),
    .level_o(d_level), .rise_o(d_rise), .fall_o(d_fall)
  );

  ds1124_input_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sync_e (
    .clk_i(clk), .rst_i(rst), .line_i(ds1124_e),
    .level_o(e_level), .rise_o(e_rise), .fall_o(e_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, sclk_level, sclk_fall, d_rise, d_fall, e_level};

  responder_state_t                 state_q;
  logic [DS1124_DELAY_W-1:0]        shift_q, shift_d;
  logic [DS1124_CNT_W-1:0]          cnt_q, cnt_d;
  logic [DS1124_DELAY_W-1:0]        delay_q;
  logic                             q_q, upd_q, err_q, busy_q;

  // Shift and saturating bit count for this cycle; frame-end sees the result.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (sclk_rise) begin
      shift_d = {shift_q[DS1124_DELAY_W-2:0], d_level};
      if (cnt_q != '1) begin
        cnt_d = cnt_q + DS1124_CNT_W'(1);
      end
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= INIT_DELAY;
      cnt_q   <= '0;
      delay_q <= INIT_DELAY;
      q_q     <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          q_q <= 1'b0;
          if (e_rise) begin
            shift_q <= delay_q;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          q_q     <= shift_q[DS1124_DELAY_W-1];
          shift_q <= shift_d;
          cnt_q   <= cnt_d;
          if (e_fall) begin
            if (cnt_d >= DS1124_CNT_W'(DS1124_BITS_PER_FRAME)) begin
              delay_q <= shift_d;
              upd_q   <= 1'b1;
            end else begin
              err_q   <= 1'b1;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ds1124_q      = q_q;
  assign delay_setting = delay_q;
  assign update_strobe = upd_q;
  assign frame_error   = err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ds1124_responder.sv
// Directed bench for ds1124_responder; the bench itself acts as the serial master.
module tb_ds1124_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       sd = 1'b0;
  logic       se = 1'b0;
  logic       q;
  logic [7:0] delay;
  logic       upd, ferr, busy;

  int n_vec = 0;
  int n_bad = 0;
  int upd_cnt = 0;
  int err_cnt = 0;
  logic [15:0] qbits;
  logic        busy_mid;

  always #5 clk = ~clk;

  ds1124_responder dut (
    .clk(clk), .rst(rst),
    .ds1124_clk(sclk), .ds1124_d(sd), .ds1124_e(se),
    .ds1124_q(q), .delay_setting(delay),
    .update_strobe(upd), .frame_error(ferr), .busy(busy)
  );

  // Count output pulse cycles away from the active edge.
  always @(negedge clk) begin
    if (upd)  upd_cnt <= upd_cnt + 1;
    if (ferr) err_cnt <= err_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master frame: n bits MSB-first from bits; Q sampled before each rising edge.
  // With coincide set, the last rising edge and E falling happen together.
  task automatic frame(input logic [15:0] bits, input int n, input bit coincide);
    qbits    = '0;
    busy_mid = 1'b0;
    upd_cnt  = 0;
    err_cnt  = 0;
    se = 1'b1;
    tick(8);
    busy_mid = busy;
    for (int i = 0; i < n; i++) begin
      sd = bits[n-1-i];
      tick(4);
      qbits = {qbits[14:0], q};
      sclk = 1'b1;
      if (coincide && (i == n - 1)) se = 1'b0;
      tick(4);
      sclk = 1'b0;
    end
    if (!coincide) begin
      tick(4);
      se = 1'b0;
    end
    tick(12);
  endtask

  initial begin
    tick(6);
    rst = 1'b0;
    tick(2);
    check_eq("rst_delay", 16'(delay), 16'h0000);
    check_eq("rst_busy", 16'(busy), 16'h0000);
    check_eq("rst_q", 16'(q), 16'h0000);

    // Write A5 over reset value; read back INIT_DELAY on Q.
    frame(16'h00A5, 8, 1'b0);
    check_eq("a5_q", qbits, 16'h0000);
    check_eq("a5_busy", 16'(busy_mid), 16'h0001);
    check_eq("a5_delay", 16'(delay), 16'h00A5);
    check_eq("a5_strobe", 16'(upd_cnt), 16'h0001);
    check_eq("a5_err", 16'(err_cnt), 16'h0000);
    check_eq("a5_busy_end", 16'(busy), 16'h0000);

    // Write 3C; Q returns A5.
    frame(16'h003C, 8, 1'b0);
    check_eq("3c_q", qbits, 16'h00A5);
    check_eq("3c_delay", 16'(delay), 16'h003C);

    // Short frame of 5 bits: error, setting held.
    frame(16'h0016, 5, 1'b0);
    check_eq("short_q", qbits, 16'h0007);
    check_eq("short_err", 16'(err_cnt), 16'h0001);
    check_eq("short_strobe", 16'(upd_cnt), 16'h0000);
    check_eq("short_delay", 16'(delay), 16'h003C);

    // 10 bits 11_10000001: last 8 win.
    frame(16'h0381, 10, 1'b0);
    check_eq("long_q", 16'(qbits[9:2]), 16'h003C);
    check_eq("long_delay", 16'(delay), 16'h0081);
    check_eq("long_strobe", 16'(upd_cnt), 16'h0001);

    // Final rising edge coincides with E falling.
    frame(16'h0042, 8, 1'b1);
    check_eq("coin_q", qbits, 16'h0081);
    check_eq("coin_delay", 16'(delay), 16'h0042);
    check_eq("coin_strobe", 16'(upd_cnt), 16'h0001);
    check_eq("coin_err", 16'(err_cnt), 16'h0000);

    // Reset after 4 bits of an FF write.
    upd_cnt = 0;
    err_cnt = 0;
    se = 1'b1;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      sd = 1'b1;
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check_eq("rstmid_busy", 16'(busy), 16'h0000);
    check_eq("rstmid_delay", 16'(delay), 16'h0000);
    tick(4);
    se = 1'b0;
    tick(12);
    check_eq("rstmid_strobe", 16'(upd_cnt), 16'h0000);
    check_eq("rstmid_err", 16'(err_cnt), 16'h0000);
    check_eq("rstmid_busy_end", 16'(busy), 16'h0000);

    // E pulse with no clocks.
    frame(16'h0000, 0, 1'b0);
    check_eq("zero_err", 16'(err_cnt), 16'h0001);
    check_eq("zero_strobe", 16'(upd_cnt), 16'h0000);
    check_eq("zero_delay", 16'(delay), 16'h0000);

    // Loopback-style write 5A then readback frame rewriting 5A.
    frame(16'h005A, 8, 1'b0);
    check_eq("lb_wr_q", qbits, 16'h0000);
    check_eq("lb_wr_delay", 16'(delay), 16'h005A);
    frame(16'h005A, 8, 1'b0);
    check_eq("lb_rd_q", qbits, 16'h005A);
    check_eq("lb_rd_strobe", 16'(upd_cnt), 16'h0001);
    check_eq("lb_rd_delay", 16'(delay), 16'h005A);
    check_eq("lb_idle_q", 16'(q), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ds1124_responder.md
Name: ds1124_responder

Overview:
- Synthesizable slave-side model of the DS1124 3-wire serial delay-line interface (CLK/D/E in, Q out).
- It is the device end of the link that ds1124_driver masters.
- Used in loopback benches and FPGA self-test in place of a physical DS1124. It holds the programmed 8-bit delay setting and shifts the old setting out on Q while a new one shifts in.
- Oversamples the asynchronous serial lines on the local system clock.

Parameters:
- INIT_DELAY, 8'h00, delay_setting value after reset.
- SYNC_STAGES, 2, synchronizer flops per serial input (legal: >=2; elaboration-time $error otherwise).
- FILTER_LEN, 2, consecutive stable samples required when glitch filter is compiled in (legal: 1..7).

Ports:
- clk  in  1  system clock; must be >=4x ds1124_clk frequency.
- rst  in  1  synchronous, active-high reset.
- ds1124_clk  in  1  serial clock from master (asynchronous to clk).
- ds1124_d  in  1  serial data from master, MSB first.
- ds1124_e  in  1  serial enable from master, active high.
- ds1124_q  out  1  serial data to master (current MSB of shift register).
- delay_setting  out  8  latched delay value.
- update_strobe  out  1  one-cycle pulse when delay_setting is written.
- frame_error  out  1  one-cycle pulse when E falls with fewer than 8 bits shifted.
- busy  out  1  high while a frame is open (synchronized E high).

Behaviour:
- Reset (sync, active-high): state=IDLE, shift_reg=INIT_DELAY, bit_cnt=0, delay_setting=INIT_DELAY, ds1124_q=0, update_strobe=0, frame_error=0, busy=0.
- Input path: each serial input passes SYNC_STAGES flops, then one history flop for edge detect. Edge pulses are e_rise, e_fall and sclk_rise; each is one clk wide.
- IDLE:
  - ds1124_q=0.
  - On e_rise: shift_reg<=delay_setting, bit_cnt<=0, busy<=1, go to SHIFT.
  - sclk_rise with E low is ignored.
- SHIFT:
  - ds1124_q = shift_reg[7], registered.
  - On sclk_rise: shift_reg<={shift_reg[6:0], synced d}, bit_cnt saturating-increment, max 15 (4-bit).
  - On e_fall:
    - If bit_cnt>=8: delay_setting<=shift_reg (last 8 bits win) and update_strobe=1 for one cycle.
    - If bit_cnt<8: delay_setting unchanged and frame_error=1 for one cycle.
    - In both cases: busy<=0, go to IDLE.
  - Simultaneous sclk_rise and e_fall in the same cycle: the shift is applied first, then the frame-end check uses the updated shift_reg and bit_cnt.
- Q timing:
  - Q changes 1 clk after the internal sclk_rise, i.e. SYNC_STAGES+2 clk after the pin edge.
  - It is stable before the next master rising edge given the 4x ratio.
  - MSB of the old setting is valid SYNC_STAGES+2 clk after the E pin rises.
- Readback: with 8 clocks shifting in the value read, the device returns the old setting on Q and rewrites it unchanged.
- Reset mid-frame: frame abandoned, no strobe, delay_setting=INIT_DELAY.
- An E pulse with zero clocks: frame_error pulse.

Optional Feature:
- Macro: DS1124_RESP_GLITCH_FILTER_EN.
- When defined: each synchronized input passes a per-line counter filter. The filtered level changes only after FILTER_LEN consecutive equal samples differing from the current filtered level. This adds FILTER_LEN clk latency, and the clk ratio requirement becomes >=(4+FILTER_LEN)x.
- When undefined: synchronizer output feeds edge detect directly, and FILTER_LEN is unused.

Decomposition:
- ds1124_pkg contains:
  - DS1124_DELAY_W=8;
  - responder_state_t enum {IDLE, SHIFT};
  - DS1124_BITS_PER_FRAME=8.
- Sub-module ds1124_input_sync: synchronizer, optional filter and edge detect for one line. Outputs level, rise and fall. Instantiated three times.

Test Plan:
- Reset, then E high, 8 clocks with 8'hA5, E low:
  - Q bits read 8'h00 (INIT_DELAY);
  - delay_setting=8'hA5;
  - update_strobe exactly 1 cycle.
- Second frame writing 8'h3C after the 8'hA5 write: Q stream = 1,0,1,0,0,1,0,1; delay_setting=8'h3C.
- Frame with only 5 clocks: frame_error 1 cycle, delay_setting holds 8'h3C, no update_strobe.
- Frame with 10 bits 2'b11 then 8'h81: delay_setting=8'h81 (last 8 win).
- rst asserted after 4 bits of a frame writing 8'hFF: busy=0, delay_setting=INIT_DELAY. E then falls with no strobe and no error.
- ds1124_driver loopback (CLK_DIV=4, clk shared):
  - driver writes 8'h5A, then performs a read;
  - driver current_delay=8'h5A and read_valid pulses;
  - responder delay_setting remains 8'h5A.
